// File: rtl/priority_16_rr_arbiter.sv
// 16-requester arbiter with a highest-index-wins search, an optional round-robin
// rotation and a bounded hold time. All outputs are registered.
module priority_16_rr_arbiter #(
    parameter int N        = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    // "release" is a reserved word in SystemVerilog, hence the longer name.
    input  logic             release_grant,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic [7:0]       enc_out
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [4:0]       hold, hold_next;

    logic [N-1:0]     grant_next;
    logic [IDX_W-1:0] idx_next;
    logic             valid_next;
    logic [7:0]       enc_next;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             hold_limit;
    logic             end_of_grant;
    logic             arb;

    // Later loop iterations overwrite earlier ones, so the last hit in the loop
    // order is the winner: index 15 in fixed mode, ptr-1 in round-robin mode.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = N; i >= 1; i--) begin
                cand = ptr - IDX_W'(i);
                if (req[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    assign hold_limit   = (MAX_HOLD != 0) && (hold >= 5'(MAX_HOLD));
    assign end_of_grant = release_grant || !req[grant_idx] || hold_limit;
    assign arb          = (state == IDLE) || end_of_grant;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        hold_next  = hold;
        grant_next = grant;
        idx_next   = grant_idx;
        valid_next = grant_valid;
        if (arb) begin
            if (win_found) begin
                state_next          = OWNED;
                ptr_next            = win_idx;
                hold_next           = 5'd1;
                grant_next          = '0;
                grant_next[win_idx] = 1'b1;
                idx_next            = win_idx;
                valid_next          = 1'b1;
            end else begin
                state_next = IDLE;
                hold_next  = '0;
                grant_next = '0;
                idx_next   = '0;
                valid_next = 1'b0;
            end
        end else if (hold != 5'h1F) begin
            hold_next = hold + 5'd1;
        end
        enc_next = valid_next ? 8'(idx_next) : 8'hF0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold        <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            enc_out     <= 8'hF0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            hold        <= hold_next;
            grant       <= grant_next;
            grant_idx   <= idx_next;
            grant_valid <= valid_next;
            enc_out     <= enc_next;
        end
    end

endmodule

// File: tb/tb_priority_16_rr_arbiter.sv
// Directed bench for priority_16_rr_arbiter: reset, fixed and round-robin
// ordering, release, owner drop, hold-limit preemption and mid-grant reset.
module tb_priority_16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        release_grant;
    logic        mode;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic [7:0]  enc_out;

    int total = 0;
    int bad   = 0;

    priority_16_rr_arbiter #(
        .N        (16),
        .IDX_W    (4),
        .MAX_HOLD (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .release_grant (release_grant),
        .mode          (mode),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .enc_out       (enc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] idx);
        logic [15:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        check({tag, "_valid"}, 32'(grant_valid), 32'd1);
        check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
        check({tag, "_grant"}, 32'(grant), 32'(onehot));
        check({tag, "_enc"}, 32'(enc_out), {28'd0, idx});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_idx"}, 32'(grant_idx), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_enc"}, 32'(enc_out), 32'h0000_00F0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req           = '0;
        release_grant = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset holds outputs clear even with every request asserted.
        rst           = 1'b1;
        req           = 16'hFFFF;
        release_grant = 1'b0;
        mode          = 1'b1;
        step();
        check_idle("rst_a");
        step();
        check_idle("rst_b");
        rst = 1'b0;
        step();
        check_grant("post_rst", 4'd15);

        // Fixed priority: index 5 beats 2; release lets 5 win again with no bubble.
        req = 16'h0024;
        step();
        check_grant("fixed_5", 4'd5);
        release_grant = 1'b1;
        step();
        check_grant("fixed_regrant", 4'd5);
        release_grant = 1'b0;

        // Round-robin alternation between 15 and 0 with release held high.
        do_reset();
        mode = 1'b0;
        req  = 16'h8001;
        step();
        check_grant("rr_0", 4'd15);
        release_grant = 1'b1;
        step();
        check_grant("rr_1", 4'd0);
        step();
        check_grant("rr_2", 4'd15);
        step();
        check_grant("rr_3", 4'd0);
        release_grant = 1'b0;

        // Hold limit: index 8 keeps the grant exactly 15 cycles, then 4 wins.
        do_reset();
        mode = 1'b0;
        req  = 16'h0110;
        step();
        check_grant("hold_c1", 4'd8);
        for (int c = 2; c <= 15; c++) begin
            step();
            check(c == 15 ? "hold_c15_idx" : "hold_mid_idx", 32'(grant_idx), 32'd8);
        end
        step();
        check_grant("hold_preempt", 4'd4);

        // Owner drops its request without release; requester 9 takes over.
        do_reset();
        mode = 1'b1;
        req  = 16'h0008;
        step();
        check_grant("drop_own", 4'd3);
        req = 16'h0200;
        step();
        check_grant("drop_new", 4'd9);

        // Reset mid-grant drops the grant; ptr returns to 0 so 12 beats 0.
        do_reset();
        mode = 1'b0;
        req  = 16'h1000;
        step();
        check_grant("mid_own", 4'd12);
        rst = 1'b1;
        step();
        check_idle("mid_rst");
        rst = 1'b0;
        req = 16'h1001;
        step();
        check_grant("mid_after", 4'd12);

        // Release while idle is ignored and no request keeps the arbiter idle.
        do_reset();
        release_grant = 1'b1;
        step();
        check_idle("idle_rel");
        release_grant = 1'b0;
        req           = 16'h0002;
        step();
        check_grant("idle_req", 4'd1);
        req = 16'h0000;
        step();
        check_idle("all_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
